// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_gen
//  Purpose  : Instruction-fetch PC generator. Issues one fetch block per
//             accepted request, steps sequentially block by block, and
//             follows exception/ertn and branch/jump redirects. A redirect
//             that arrives while the fetch stage is stalled is parked in a
//             pending register until the stage becomes ready.
//
//  Ports
//    clk_i              in   1         clock, all state on rising edge
//    rst_i              in   1         asynchronous active-high reset
//    excp_bus_i         in   PC_W+1    {taken, target} exception/ertn redirect
//    jbr_bus_i          in   PC_W+1    {taken, target} branch/jump redirect
//    ctl_if_allow_in_i  in   1         downstream ready
//    ctl_if_valid_o     out  1         fetch request valid
//    if_pc_o            out  PC_W      fetch start PC (may point mid-block)
//    if_slot_mask_o     out  FETCH_N   valid instruction slots in the block
//    if_adef_o          out  1         misaligned fetch PC, qualified by valid
//    redir_pending_o    out  1         buffered redirect waiting for ready
//
//  Parameters
//    PC_W      PC width in bits
//    RESET_PC  first fetch address after reset
//    FETCH_N   instructions per fetch block (1, 2, 4 or 8)
//
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_gen #(
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = 'h1C00_0000,
    parameter int unsigned      FETCH_N  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PC_W:0]       excp_bus_i,
    input  logic [PC_W:0]       jbr_bus_i,
    input  logic                ctl_if_allow_in_i,
    output logic                ctl_if_valid_o,
    output logic [PC_W-1:0]     if_pc_o,
    output logic [FETCH_N-1:0]  if_slot_mask_o,
    output logic                if_adef_o,
    output logic                redir_pending_o
);

    // ------------------------------------------------------------------
    // Block geometry
    // ------------------------------------------------------------------
    localparam int unsigned     c_BLK            = FETCH_N * 4;
    localparam int unsigned     c_LOG2_BLK       = $clog2(c_BLK);
    localparam logic [PC_W-1:0] c_BLK_BYTES      = PC_W'(c_BLK);
    localparam logic [PC_W-1:0] c_BLK_ALIGN_MASK = ~(c_BLK_BYTES - PC_W'(1));

    // ------------------------------------------------------------------
    // State encoding
    //   BOOT : single settling cycle after reset, no fetch issued
    //   RUN  : normal fetching
    //   HOLD : a redirect is parked, waiting for downstream ready
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    r_pending;
    logic [PC_W-1:0]    w_pending_nxt;

    logic               w_excp_taken;
    logic               w_jbr_taken;
    logic               w_redir_taken;
    logic [PC_W-1:0]    w_redir_target;
    logic [PC_W-1:0]    w_seq_pc;
    logic               w_fetch_valid;
    logic               w_hold;

    // ------------------------------------------------------------------
    // Redirect selection: exception/ertn always wins over branch/jump.
    // ------------------------------------------------------------------
    assign w_excp_taken   = excp_bus_i[PC_W];
    assign w_jbr_taken    = jbr_bus_i[PC_W];
    assign w_redir_taken  = w_excp_taken | w_jbr_taken;
    assign w_redir_target = w_excp_taken ? excp_bus_i[PC_W-1:0]
                                         : jbr_bus_i[PC_W-1:0];

    // Sequential successor: start of the next block. Clearing the low bits
    // here is what realigns a fetch that entered mid-block (or misaligned).
    assign w_seq_pc = (r_pc & c_BLK_ALIGN_MASK) + c_BLK_BYTES;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_PC;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pending_nxt = r_pending;
        w_fetch_valid = 1'b0;
        w_hold        = 1'b0;

        case (r_state)
            ST_BOOT: begin
                // Redirects are ignored; the first fetch is always RESET_PC.
                w_state_nxt = ST_RUN;
                w_pc_nxt    = RESET_PC;
            end

            ST_RUN: begin
                // A redirect in flight squashes the current request so the
                // wrong-path block is never presented downstream.
                w_fetch_valid = ~w_redir_taken;
                if (w_redir_taken) begin
                    if (ctl_if_allow_in_i) begin
                        w_pc_nxt = w_redir_target;
                    end else begin
                        w_pending_nxt = w_redir_target;
                        w_state_nxt   = ST_HOLD;
                    end
                end else if (ctl_if_allow_in_i) begin
                    w_pc_nxt = w_seq_pc;
                end
            end

            ST_HOLD: begin
                w_hold = 1'b1;
                // The most recent redirect supersedes whatever was parked.
                if (w_redir_taken) begin
                    w_pending_nxt = w_redir_target;
                end
                if (ctl_if_allow_in_i) begin
                    w_pc_nxt      = w_redir_taken ? w_redir_target : r_pending;
                    w_pending_nxt = '0;
                    w_state_nxt   = ST_RUN;
                end
            end

            default: begin
                w_state_nxt   = ST_BOOT;
                w_pc_nxt      = RESET_PC;
                w_pending_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. All are functions of registered state plus the same-cycle
    // redirect squash, so an asynchronous reset reaches them immediately.
    // ------------------------------------------------------------------
    assign ctl_if_valid_o  = w_fetch_valid;
    assign if_pc_o         = r_pc;
    assign if_adef_o       = w_fetch_valid & (|r_pc[1:0]);
    assign redir_pending_o = w_hold;

    // Slot mask: slots before the entry slot of the block are not valid.
    generate
        if (FETCH_N == 1) begin : g_mask_single
            assign if_slot_mask_o = 1'b1;
        end else begin : g_mask_multi
            localparam int unsigned c_IDX_W = $clog2(FETCH_N);
            logic [c_IDX_W-1:0] w_slot_idx;

            assign w_slot_idx = r_pc[c_LOG2_BLK-1:2];

            for (genvar i = 0; i < FETCH_N; i++) begin : g_slot
                assign if_slot_mask_o[i] = (c_IDX_W'(i) >= w_slot_idx);
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_pc_gen
//  Purpose  : Self-checking bench for fetch_pc_gen (FETCH_N=2,
//             RESET_PC=0x1C000000): directed vector table, hand-written
//             asynchronous-reset sequence, and randomized stimulus compared
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h1C00_0000;
    localparam int unsigned FETCH_N  = 2;
    localparam int unsigned BLK      = FETCH_N * 4;
    localparam int unsigned N_RAND   = 2000;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [PC_W:0]      excp_bus_i;
    logic [PC_W:0]      jbr_bus_i;
    logic               ctl_if_allow_in_i;
    logic               ctl_if_valid_o;
    logic [PC_W-1:0]    if_pc_o;
    logic [FETCH_N-1:0] if_slot_mask_o;
    logic               if_adef_o;
    logic               redir_pending_o;

    fetch_pc_gen #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .FETCH_N  (FETCH_N)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .excp_bus_i        (excp_bus_i),
        .jbr_bus_i         (jbr_bus_i),
        .ctl_if_allow_in_i (ctl_if_allow_in_i),
        .ctl_if_valid_o    (ctl_if_valid_o),
        .if_pc_o           (if_pc_o),
        .if_slot_mask_o    (if_slot_mask_o),
        .if_adef_o         (if_adef_o),
        .redir_pending_o   (redir_pending_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [31:0] pc,
                            input logic [1:0] mask, input logic adef, input logic pend);
        chk({tag, " valid"}, 32'(ctl_if_valid_o), 32'(v));
        chk({tag, " pc"},    if_pc_o,             pc);
        chk({tag, " mask"},  32'(if_slot_mask_o), 32'(mask));
        chk({tag, " adef"},  32'(if_adef_o),      32'(adef));
        chk({tag, " pend"},  32'(redir_pending_o), 32'(pend));
    endtask

    task automatic drive(input logic et, input logic [31:0] etg,
                         input logic jt, input logic [31:0] jtg, input logic allow);
        excp_bus_i        = {et, etg};
        jbr_bus_i         = {jt, jtg};
        ctl_if_allow_in_i = allow;
    endtask

    // Advance to the next cycle's drive point (1 time unit after the edge).
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        et;
        logic [31:0] etg;
        logic        jt;
        logic [31:0] jtg;
        logic        allow;
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  mask;
        logic        adef;
        logic        pend;
    } vec_t;

    localparam int N_VEC = 28;
    vec_t vecs [N_VEC];
    vec_t v;

    function automatic vec_t mk(input logic et, input logic [31:0] etg,
                                input logic jt, input logic [31:0] jtg, input logic allow,
                                input logic valid, input logic [31:0] pc,
                                input logic [1:0] mask, input logic adef, input logic pend);
        vec_t r;
        r.et = et; r.etg = etg; r.jt = jt; r.jtg = jtg; r.allow = allow;
        r.valid = valid; r.pc = pc; r.mask = mask; r.adef = adef; r.pend = pend;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: plain arithmetic on the architectural rules.
    // ------------------------------------------------------------------
    logic        m_booting;
    logic        m_holding;
    logic [31:0] m_pc;
    logic [31:0] m_pend;

    function automatic logic [1:0] model_mask(input logic [31:0] pc);
        int unsigned slot;
        int unsigned full;
        slot = (pc % BLK) / 4;
        full = (1 << FETCH_N) - 1;
        return 2'(full & ~((1 << slot) - 1));
    endfunction

    task automatic model_reset();
        m_booting = 1'b1;
        m_holding = 1'b0;
        m_pc      = RESET_PC;
        m_pend    = '0;
    endtask

    logic [31:0] rnd_val;

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = $urandom & 32'hFFFF_FFF8;
            1:       t = $urandom;
            2:       t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
            default: t = RESET_PC + ($urandom_range(0, 63));
        endcase
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        et, jt, allow, any, exp_valid;
        logic [31:0] etg, jtg, tgt;

        // ---- table contents ----
        vecs[0]  = mk(0, 0, 1, 32'h1234_5678, 1,  0, RESET_PC,     2'b11, 0, 0); // BOOT ignores redirect
        vecs[1]  = mk(0, 0, 0, 0, 1,              1, 32'h1C000000, 2'b11, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1,              1, 32'h1C000008, 2'b11, 0, 0);
        vecs[3]  = mk(0, 0, 1, 32'h1C000104, 1,   0, 32'h1C000010, 2'b11, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1,              1, 32'h1C000104, 2'b10, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1,              1, 32'h1C000108, 2'b11, 0, 0);
        vecs[6]  = mk(0, 0, 1, 32'h1C000200, 0,   0, 32'h1C000110, 2'b11, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0,              0, 32'h1C000110, 2'b11, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0,              0, 32'h1C000110, 2'b11, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 1,              0, 32'h1C000110, 2'b11, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 1,              1, 32'h1C000200, 2'b11, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0,              1, 32'h1C000208, 2'b11, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0,              1, 32'h1C000208, 2'b11, 0, 0);
        vecs[13] = mk(1, 32'h1C008000, 1, 32'h1C000200, 1, 0, 32'h1C000208, 2'b11, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 1,              1, 32'h1C008000, 2'b11, 0, 0);
        vecs[15] = mk(1, 32'hFFFFFFF8, 0, 0, 1,   0, 32'h1C008008, 2'b11, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 1,              1, 32'hFFFFFFF8, 2'b11, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 1,              1, 32'h00000000, 2'b11, 0, 0);
        vecs[18] = mk(0, 0, 1, 32'h1C000006, 1,   0, 32'h00000008, 2'b11, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 1,              1, 32'h1C000006, 2'b10, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 1,              1, 32'h1C000008, 2'b11, 0, 0);
        vecs[21] = mk(0, 0, 1, 32'h1C000300, 0,   0, 32'h1C000010, 2'b11, 0, 0);
        vecs[22] = mk(1, 32'h1C000400, 0, 0, 0,   0, 32'h1C000010, 2'b11, 0, 1);
        vecs[23] = mk(0, 0, 1, 32'h1C000500, 1,   0, 32'h1C000010, 2'b11, 0, 1);
        vecs[24] = mk(0, 0, 0, 0, 1,              1, 32'h1C000500, 2'b11, 0, 0);
        vecs[25] = mk(0, 0, 1, 32'h1C000404, 0,   0, 32'h1C000508, 2'b11, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 1,              0, 32'h1C000508, 2'b11, 0, 1);
        vecs[27] = mk(0, 0, 0, 0, 1,              1, 32'h1C000404, 2'b10, 0, 0);

        // ---- reset state ----
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 1);
        #1;
        chk_outs("reset", 0, RESET_PC, 2'b11, 0, 0);
        @(posedge clk_i);
        next_cycle();
        rst_i = 1'b0;

        // ---- directed table: row 0 is the BOOT cycle ----
        for (int i = 0; i < N_VEC; i++) begin
            v = vecs[i];
            drive(v.et, v.etg, v.jt, v.jtg, v.allow);
            @(negedge clk_i);
            chk_outs($sformatf("row%0d", i), v.valid, v.pc, v.mask, v.adef, v.pend);
            next_cycle();
        end

        // ---- asynchronous reset between edges while in HOLD ----
        drive(0, 0, 1, 32'h1C000700, 0);
        @(negedge clk_i);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk_outs("pre_rst_hold", 0, 32'h1C000408, 2'b11, 0, 1);
        #1;
        rst_i = 1'b1;
        #1;
        chk_outs("async_rst", 0, RESET_PC, 2'b11, 0, 0);
        next_cycle();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 1);
        @(negedge clk_i);
        chk_outs("post_rst_boot", 0, RESET_PC, 2'b11, 0, 0);
        next_cycle();
        @(negedge clk_i);
        chk_outs("post_rst_run", 1, RESET_PC, 2'b11, 0, 0);
        next_cycle();

        // ---- randomized run against the reference model ----
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        model_reset();
        for (int c = 0; c < N_RAND; c++) begin
            et    = ($urandom_range(0, 99) < 10);
            jt    = ($urandom_range(0, 99) < 20);
            etg   = rand_target();
            jtg   = rand_target();
            allow = ($urandom_range(0, 99) < 65);
            drive(et, etg, jt, jtg, allow);

            any       = et | jt;
            tgt       = et ? etg : jtg;
            exp_valid = !m_booting && !m_holding && !any;

            @(negedge clk_i);
            chk_outs($sformatf("rnd%0d", c), exp_valid, m_pc, model_mask(m_pc),
                     exp_valid && (m_pc % 4 != 0), m_holding);

            if (m_booting) begin
                m_booting = 1'b0;
                m_pc      = RESET_PC;
            end else if (m_holding) begin
                if (any) m_pend = tgt;
                if (allow) begin
                    m_pc      = m_pend;
                    m_pend    = '0;
                    m_holding = 1'b0;
                end
            end else if (any) begin
                if (allow) begin
                    m_pc = tgt;
                end else begin
                    m_pend    = tgt;
                    m_holding = 1'b1;
                end
            end else if (allow) begin
                m_pc = m_pc - (m_pc % BLK) + BLK;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h1C00_0000, first fetch address after reset.
REQ-003 SHALL have parameter FETCH_N, default 2, instructions per fetch block; legal values 1, 2, 4, 8; block size BLK = FETCH_N*4 bytes.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-007 SHALL have port excp_bus_i  input  PC_W+1  {taken, target}, exception/ertn redirect, highest priority.
REQ-008 SHALL have port jbr_bus_i  input  PC_W+1  {taken, target}, branch/jump redirect.
REQ-009 SHALL have port ctl_if_allow_in_i  input  1  downstream ready.
REQ-010 SHALL have port ctl_if_valid_o  output  1  fetch request valid.
REQ-011 SHALL have port if_pc_o  output  PC_W  fetch start PC; may point mid-block.
REQ-012 SHALL have port if_slot_mask_o  output  FETCH_N  valid instruction slots in block.
REQ-013 SHALL have port if_adef_o  output  1  if_pc_o[1:0] != 0, qualified by ctl_if_valid_o.
REQ-014 SHALL have port redir_pending_o  output  1  buffered redirect waiting for ready.

Function
REQ-015 SHALL implement states BOOT, RUN, HOLD; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-016 SHALL drive ctl_if_valid_o = 1 only in RUN when no redirect is taken that cycle; 0 in BOOT and HOLD.
REQ-017 SHALL treat a fetch as accepted when ctl_if_valid_o && ctl_if_allow_in_i.
REQ-018 SHALL, on accept with no redirect, load pc <= (pc with low log2(BLK) bits cleared) + BLK, modulo 2^PC_W.
REQ-019 SHALL, when ctl_if_valid_o && !ctl_if_allow_in_i, hold if_pc_o, if_slot_mask_o, if_adef_o stable.
REQ-020 SHALL select redirect target with priority excp_bus_i over jbr_bus_i when both taken in the same cycle.
REQ-021 SHALL, on a taken redirect in RUN with ctl_if_allow_in_i=1, load pc <= target next cycle, stay RUN.
REQ-022 SHALL, on a taken redirect in RUN with ctl_if_allow_in_i=0, capture target in a pending register and enter HOLD.
REQ-023 SHALL, in HOLD, overwrite pending with any new taken redirect (priority per REQ-020).
REQ-024 SHALL, in HOLD with ctl_if_allow_in_i=1, load pc <= pending (or the new redirect target if one is taken that cycle), clear pending, enter RUN.
REQ-025 SHALL drive redir_pending_o = 1 exactly while in HOLD.
REQ-026 SHALL set if_slot_mask_o bit i iff i >= pc[log2(BLK)-1:2]; FETCH_N=1 gives constant 1.
REQ-027 SHALL load a misaligned target unchanged; the next sequential step clears the low bits per REQ-018.
REQ-028 SHALL ignore redirects in BOOT; BOOT always exits with pc = RESET_PC.

Reset
REQ-029 SHALL, on rst_i assertion, immediately without clock set: state BOOT, pc RESET_PC, pending 0, ctl_if_valid_o 0, redir_pending_o 0, if_pc_o RESET_PC, if_adef_o 0.
REQ-030 SHALL abandon any in-progress HOLD or stall on reset; no pending target survives.

Verification (FETCH_N=2, RESET_PC=0x1C000000)
REQ-031 SHALL cover: release reset, allow=1 -> cycle0 valid=0; cycle1 pc=0x1C000000 mask=11 valid=1; cycle2 pc=0x1C000008.
REQ-032 SHALL cover: jbr target 0x1C000104, allow=1 -> valid=0 that cycle; next pc=0x1C000104 mask=10; then pc=0x1C000108 mask=11.
REQ-033 SHALL cover: jbr target 0x1C000200 with allow=0 for 3 cycles -> redir_pending_o=1, valid=0; allow=1 -> next cycle pc=0x1C000200 valid=1, pending=0.
REQ-034 SHALL cover: excp 0x1C008000 and jbr 0x1C000200 same cycle -> pc=0x1C008000.
REQ-035 SHALL cover: pc=0xFFFFFFF8 accepted -> next pc=0x00000000; target 0x1C000006 -> if_adef_o=1, then pc=0x1C000008.
REQ-036 SHALL cover: rst_i asserted mid-HOLD between clock edges -> all outputs at REQ-029 values before next edge.
